// File: rtl/cordic_vectoring_if.sv
// Handshake and data bundle for the CORDIC vectoring engine.
// The requester drives start/x/y; the engine returns ready/done and the polar result.
interface cordic_vectoring_if;
  logic               start;
  logic signed [31:0] x;
  logic signed [31:0] y;
  logic               ready;
  logic               done;
  logic        [31:0] magnitude;
  logic        [31:0] angle;

  modport master (
    output start, x, y,
    input  ready, done, magnitude, angle
  );

  modport slave (
    input  start, x, y,
    output ready, done, magnitude, angle
  );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative circular-mode CORDIC vectoring: (x, y) -> (magnitude, atan2 angle),
// one micro-rotation per clock. Angle units: 2^31 = 360 degrees.
module cordic_vectoring #(
  parameter int NUMBER_OF_ITERATIONS = 29
) (
  input  logic              clock,
  input  logic              reset_n,
  cordic_vectoring_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] INV_GAIN   = 32'h9B74EDA8;
  localparam logic [31:0] HALF_TURN  = 32'h40000000;
  localparam logic [31:0] ANGLE_MASK = 32'h7FFFFFFF;
  localparam logic [4:0]  LAST_ITER  = 5'(NUMBER_OF_ITERATIONS - 1);

  function automatic logic [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = 32'h10000000;
      5'd1:    atan_lut = 32'h09720290;
      5'd2:    atan_lut = 32'h04FD9C2E;
      5'd3:    atan_lut = 32'h028888EA;
      5'd4:    atan_lut = 32'h014586A2;
      5'd5:    atan_lut = 32'h00A2EBF1;
      5'd6:    atan_lut = 32'h00517B0F;
      5'd7:    atan_lut = 32'h0028BE2B;
      5'd8:    atan_lut = 32'h00145F2A;
      5'd9:    atan_lut = 32'h000A2F98;
      5'd10:   atan_lut = 32'h000517CC;
      5'd11:   atan_lut = 32'h00028BE6;
      5'd12:   atan_lut = 32'h000145F3;
      5'd13:   atan_lut = 32'h0000A2FA;
      5'd14:   atan_lut = 32'h0000517D;
      5'd15:   atan_lut = 32'h000028BE;
      5'd16:   atan_lut = 32'h0000145F;
      5'd17:   atan_lut = 32'h00000A30;
      5'd18:   atan_lut = 32'h00000518;
      5'd19:   atan_lut = 32'h0000028C;
      5'd20:   atan_lut = 32'h00000146;
      5'd21:   atan_lut = 32'h000000A3;
      5'd22:   atan_lut = 32'h00000051;
      5'd23:   atan_lut = 32'h00000029;
      5'd24:   atan_lut = 32'h00000014;
      5'd25:   atan_lut = 32'h0000000A;
      5'd26:   atan_lut = 32'h00000005;
      5'd27:   atan_lut = 32'h00000003;
      5'd28:   atan_lut = 32'h00000001;
      5'd29:   atan_lut = 32'h00000001;
      5'd30:   atan_lut = 32'h00000000;
      5'd31:   atan_lut = 32'h00000000;
      default: atan_lut = 32'h00000000;
    endcase
  endfunction

  state_t             state_r, state_s;
  logic signed [33:0] xr_r, xr_s;
  logic signed [33:0] yr_r, yr_s;
  logic signed [31:0] zr_r, zr_s;
  logic        [4:0]  i_r, i_s;
  logic               zero_r, zero_s;
  logic               ready_r, ready_s;
  logic               done_r, done_s;
  logic        [31:0] mag_r, mag_s;
  logic        [31:0] ang_r, ang_s;

  logic signed [33:0] x_ext_s, y_ext_s;
  logic signed [33:0] x_shift_s, y_shift_s;
  logic signed [31:0] atan_s;
  logic               accept_s;

  // Next-state, datapath and output computation.
  always_comb begin
    x_ext_s   = {{2{bus.x[31]}}, bus.x};
    y_ext_s   = {{2{bus.y[31]}}, bus.y};
    x_shift_s = xr_r >>> i_r;
    y_shift_s = yr_r >>> i_r;
    atan_s    = $signed(atan_lut(i_r));
    accept_s  = bus.start && ready_r;

    state_s = state_r;
    xr_s    = xr_r;
    yr_s    = yr_r;
    zr_s    = zr_r;
    i_s     = i_r;
    zero_s  = zero_r;
    ready_s = ready_r;
    done_s  = 1'b0;
    mag_s   = mag_r;
    ang_s   = ang_r;

    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          // Left half-plane: rotate by 180 degrees first so the iterations converge.
          if (bus.x[31]) begin
            xr_s = -x_ext_s;
            yr_s = -y_ext_s;
            zr_s = $signed(HALF_TURN);
          end else begin
            xr_s = x_ext_s;
            yr_s = y_ext_s;
            zr_s = 32'sd0;
          end
          zero_s  = (bus.x == 32'sd0) && (bus.y == 32'sd0);
          i_s     = 5'd0;
          ready_s = 1'b0;
          state_s = ITER;
        end else begin
          ready_s = 1'b1;
          state_s = IDLE;
        end
      end
      ITER: begin
        if (!yr_r[33]) begin
          xr_s = xr_r + y_shift_s;
          yr_s = yr_r - x_shift_s;
          zr_s = zr_r + atan_s;
        end else begin
          xr_s = xr_r - y_shift_s;
          yr_s = yr_r + x_shift_s;
          zr_s = zr_r - atan_s;
        end
        i_s = i_r + 5'd1;
        if (i_r == LAST_ITER) begin
          state_s = SCALE;
        end else begin
          state_s = ITER;
        end
      end
      SCALE: begin
        mag_s   = 32'((64'($unsigned(xr_r)) * 64'(INV_GAIN)) >> 32);
        // A zero vector never drives yr negative, so zr would sum the whole table.
        ang_s   = zero_r ? 32'h00000000 : ($unsigned(zr_r) & ANGLE_MASK);
        done_s  = 1'b1;
        ready_s = 1'b1;
        state_s = DONE;
      end
      default: begin
        ready_s = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
      xr_r    <= 34'sd0;
      yr_r    <= 34'sd0;
      zr_r    <= 32'sd0;
      i_r     <= 5'd0;
      zero_r  <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      mag_r   <= 32'h00000000;
      ang_r   <= 32'h00000000;
    end else begin
      state_r <= state_s;
      xr_r    <= xr_s;
      yr_r    <= yr_s;
      zr_r    <= zr_s;
      i_r     <= i_s;
      zero_r  <= zero_s;
      ready_r <= ready_s;
      done_r  <= done_s;
      mag_r   <= mag_s;
      ang_r   <= ang_s;
    end
  end

  assign bus.ready     = ready_r;
  assign bus.done      = done_r;
  assign bus.magnitude = mag_r;
  assign bus.angle     = ang_r;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring: fixed vector table, random vectors
// against a real-arithmetic polar model, and handshake corner sequences.
module tb_cordic_vectoring;
  localparam int  N    = 29;
  localparam int  LAT  = N + 1;
  localparam real PI   = 3.14159265358979323846;
  localparam real TURN = 2147483648.0;

  logic clock;
  logic reset_n;

  cordic_vectoring_if bus ();

  cordic_vectoring #(.NUMBER_OF_ITERATIONS(N)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int applied;
  int miscompares;

  typedef struct {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic        [31:0] mag;
    logic        [31:0] ang;
  } vec_t;

  vec_t table_v [9];

  function automatic real model_mag(input logic signed [31:0] vx, input logic signed [31:0] vy);
    real rx, ry;
    rx = $itor(vx);
    ry = $itor(vy);
    return $sqrt(rx * rx + ry * ry);
  endfunction

  function automatic real model_ang(input logic signed [31:0] vx, input logic signed [31:0] vy);
    real a;
    a = $atan2($itor(vy), $itor(vx)) * TURN / (2.0 * PI);
    if (a < 0.0) a = a + TURN;
    return a;
  endfunction

  task automatic check_val(input string name, input longint act, input longint exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_mag(input string name, input logic [31:0] act, input real exp);
    real tol, diff;
    tol  = (exp == 0.0) ? 0.0 : exp / 16777216.0 + 4.0;
    diff = real'(longint'(act)) - exp;
    applied++;
    if (diff > tol || diff < -tol) begin
      miscompares++;
      $display("FAIL %s: magnitude got %0d, want %.1f +/- %.1f", name, act, exp, tol);
    end
  endtask

  task automatic check_ang(input string name, input logic [31:0] act, input real exp);
    real diff;
    diff = real'(longint'(act)) - exp;
    if (diff > TURN / 2.0) diff = diff - TURN;
    else if (diff < -TURN / 2.0) diff = diff + TURN;
    applied++;
    if (diff > 16.0 || diff < -16.0) begin
      miscompares++;
      $display("FAIL %s: angle got 0x%08h, want %.1f +/- 16", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int waited;
    waited = 0;
    @(negedge clock);
    while (!bus.ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
  endtask

  // Accept one vector and wait (bounded) for done; lat = edges from accept to done.
  task automatic run_vec(input logic signed [31:0] vx, input logic signed [31:0] vy,
                         output logic [31:0] mag, output logic [31:0] ang, output int lat);
    wait_ready();
    bus.x     = vx;
    bus.y     = vy;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
      if (bus.done) break;
    end
    mag = bus.magnitude;
    ang = bus.angle;
  endtask

  initial begin
    logic        [31:0] mag_v, ang_v, mag_a, ang_a, mag_b, ang_b;
    logic signed [31:0] rx, ry;
    longint             ax, ay;
    int                 lat, first, second, ndone;

    applied     = 0;
    miscompares = 0;

    table_v[0] = '{32'sh10000000, 32'sh00000000, 32'h10000000, 32'h00000000};
    table_v[1] = '{32'sh10000000, 32'sh10000000, 32'h16A09E66, 32'h10000000};
    table_v[2] = '{-32'sd268435456, 32'sh00000000, 32'h10000000, 32'h40000000};
    table_v[3] = '{32'sh00000000, -32'sd268435456, 32'h10000000, 32'h60000000};
    table_v[4] = '{-32'sd268435456, -32'sd268435456, 32'h16A09E66, 32'h50000000};
    table_v[5] = '{32'sh00000000, 32'sh10000000, 32'h10000000, 32'h20000000};
    // atan2(4,3) = 53.13 deg in 2^31-per-turn units
    table_v[6] = '{32'sh0C000000, 32'sh10000000, 32'h14000000, 32'd316933406};
    table_v[7] = '{32'sh80000000, 32'sh00000000, 32'h80000000, 32'h40000000};
    table_v[8] = '{32'sh00000000, 32'sh00000000, 32'h00000000, 32'h00000000};

    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.x     = 32'sd0;
    bus.y     = 32'sd0;
    repeat (3) @(posedge clock);
    #1;
    check_val("reset_ready", bus.ready, 1);
    check_val("reset_done", bus.done, 0);
    check_val("reset_magnitude", bus.magnitude, 0);
    check_val("reset_angle", bus.angle, 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      run_vec(table_v[k].x, table_v[k].y, mag_v, ang_v, lat);
      check_val($sformatf("table%0d_latency", k), lat, LAT);
      check_mag($sformatf("table%0d", k), mag_v, real'(longint'(table_v[k].mag)));
      check_ang($sformatf("table%0d", k), ang_v, real'(longint'(table_v[k].ang)));
      @(posedge clock);
      #1;
      check_val($sformatf("table%0d_done_pulse", k), bus.done, 0);
    end

    for (int k = 0; k < 24; k++) begin
      rx = $urandom;
      ry = $urandom;
      ax = (rx < 0) ? -longint'(rx) : longint'(rx);
      ay = (ry < 0) ? -longint'(ry) : longint'(ry);
      if (ax < 64'sd536870912 && ay < 64'sd536870912) rx[30] = ~rx[31];
      run_vec(rx, ry, mag_v, ang_v, lat);
      check_val($sformatf("rand%0d_latency", k), lat, LAT);
      check_mag($sformatf("rand%0d x=%0d y=%0d", k, rx, ry), mag_v, model_mag(rx, ry));
      check_ang($sformatf("rand%0d x=%0d y=%0d", k, rx, ry), ang_v, model_ang(rx, ry));
    end

    // Start pulsed while busy must be ignored.
    wait_ready();
    bus.x = 32'sh0C000000; bus.y = 32'sh10000000; bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    first = 0; ndone = 0;
    for (int e = 1; e <= 3 * LAT; e++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        ndone++;
        if (first == 0) begin
          first = e; mag_v = bus.magnitude; ang_v = bus.angle;
        end
      end
      if (e == 4) begin
        bus.x = -32'sd100000000; bus.y = 32'sd5; bus.start = 1'b1;
      end else if (e == 5) begin
        check_val("busy_ready_low", bus.ready, 0);
        bus.start = 1'b0;
      end
    end
    check_val("busy_done_count", ndone, 1);
    check_val("busy_latency", first, LAT);
    check_mag("busy_result", mag_v, model_mag(32'sh0C000000, 32'sh10000000));
    check_ang("busy_result", ang_v, model_ang(32'sh0C000000, 32'sh10000000));

    // Start held high through done: second run accepted on the edge ending done.
    wait_ready();
    bus.x = 32'sh10000000; bus.y = 32'sh10000000; bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.x = -32'sd268435456; bus.y = 32'sh0C000000;
    first = 0; second = 0;
    mag_a = 32'h0; ang_a = 32'h0; mag_b = 32'h0; ang_b = 32'h0;
    for (int e = 1; e <= 3 * LAT; e++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        if (first == 0) begin
          first = e; mag_a = bus.magnitude; ang_a = bus.angle;
        end else if (second == 0) begin
          second = e; mag_b = bus.magnitude; ang_b = bus.angle;
        end
      end
      if (first != 0 && e == first + 1) begin
        check_val("b2b_reaccept_ready", bus.ready, 0);
        check_val("b2b_reaccept_done", bus.done, 0);
        bus.start = 1'b0;
      end
      if (second != 0) break;
    end
    bus.start = 1'b0;
    check_val("b2b_first_latency", first, LAT);
    check_val("b2b_second_done", second, 2 * LAT + 1);
    check_mag("b2b_first", mag_a, model_mag(32'sh10000000, 32'sh10000000));
    check_ang("b2b_first", ang_a, model_ang(32'sh10000000, 32'sh10000000));
    check_mag("b2b_second", mag_b, model_mag(-32'sd268435456, 32'sh0C000000));
    check_ang("b2b_second", ang_b, model_ang(-32'sd268435456, 32'sh0C000000));

    // Reset mid-run aborts: no done, outputs cleared.
    wait_ready();
    bus.x = 32'sh10000000; bus.y = 32'sh0C000000; bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    ndone = 0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clock);
      #1;
      if (bus.done) ndone++;
    end
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check_val("abort_ready", bus.ready, 1);
    check_val("abort_done", bus.done, 0);
    check_val("abort_magnitude", bus.magnitude, 0);
    check_val("abort_angle", bus.angle, 0);
    for (int e = 1; e <= 2 * LAT; e++) begin
      @(posedge clock);
      #1;
      if (bus.done) ndone++;
    end
    check_val("abort_no_done", ndone, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
